jtsdram_rnd_seq: RTL and testbench

Self-checking random-pattern sequencer for one SDRAM bank port in the SDRAM test core. It holds its own 16-bit Fibonacci LFSR, writes a block of pseudo-random words, then replays the LFSR from the saved seed to read the block back and compare. Each pass chains its seed from the previous pass. It drives the bank request/ack/ready handshake and reports pass count, error count and a sticky fail flag to the test UI.

---
 rtl/jtsdram_rnd_seq.sv | 199 +++++++++++++++++++
 tb/tb_jtsdram_rnd_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtsdram_rnd_seq.sv
// Random-pattern SDRAM bank sequencer: writes 2^LW LFSR words, replays the LFSR from the saved seed and compares.
// Registered outputs; one request in flight, held until ack; each pass seeds from the previous pass's final LFSR.
module jtsdram_rnd_seq #(
    parameter int          AW   = 22,
    parameter int          LW   = 8,
    parameter logic [15:0] SEED = 16'hcafe
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          loop,
    output logic          busy,
    output logic          done,
    output logic          bad,
    output logic [15:0]   err_cnt,
    output logic [7:0]    pass_cnt,
    output logic [AW-1:0] ba_addr,
    output logic          ba_wr,
    output logic          ba_rd,
    output logic [15:0]   ba_din,
    input  logic          ba_ack,
    input  logic          ba_rdy,
    input  logic [15:0]   ba_dout
);

    localparam int PW = AW - LW;

    typedef enum logic [3:0] {
        S_IDLE, S_PSTART, S_WR, S_WGAP, S_RSTART,
        S_RD, S_RWAIT, S_RGAP, S_PEND, S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_seed, w_seed;
    logic [15:0]   r_lfsr, w_lfsr, w_lfsr_adv;
    logic [PW-1:0] r_page, w_page;
    logic [LW-1:0] r_cnt, w_cnt;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_bad, w_bad;
    logic [15:0]   r_err_cnt, w_err_cnt;
    logic [7:0]    r_pass_cnt, w_pass_cnt;
    logic [AW-1:0] r_ba_addr, w_ba_addr;
    logic          r_ba_wr, w_ba_wr;
    logic          r_ba_rd, w_ba_rd;
    logic [15:0]   r_ba_din, w_ba_din;

    logic w_start_ok, w_wr_ack, w_rd_ack, w_cmp, w_last;

    assign w_lfsr_adv = {r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[9] ^
                         r_lfsr[7]  ^ r_lfsr[4]  ^ r_lfsr[2]  ^ r_lfsr[0],
                         r_lfsr[15:1]};

    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
    // ack only counts once the registered request is actually on the bus
    assign w_wr_ack   = (r_state == S_WR) && r_ba_wr && ba_ack;
    assign w_rd_ack   = (r_state == S_RD) && r_ba_rd && ba_ack;
    assign w_cmp      = (w_rd_ack && ba_rdy) || (r_state == S_RWAIT && ba_rdy);
    assign w_last     = (r_cnt == {LW{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start_ok) w_state_nxt = S_PSTART;
            S_PSTART:       w_state_nxt = S_WR;
            S_WR:           if (w_wr_ack) w_state_nxt = w_last ? S_RSTART : S_WGAP;
            S_WGAP:         w_state_nxt = S_WR;
            S_RSTART:       w_state_nxt = S_RD;
            S_RD: begin
                if (w_cmp)         w_state_nxt = w_last ? S_PEND : S_RGAP;
                else if (w_rd_ack) w_state_nxt = S_RWAIT;
            end
            S_RWAIT:        if (w_cmp) w_state_nxt = w_last ? S_PEND : S_RGAP;
            S_RGAP:         w_state_nxt = S_RD;
            S_PEND:         w_state_nxt = loop ? S_PSTART : S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_seed     = r_seed;
        w_lfsr     = r_lfsr;
        w_page     = r_page;
        w_cnt      = r_cnt;
        w_busy     = r_busy;
        w_done     = r_done;
        w_bad      = r_bad;
        w_err_cnt  = r_err_cnt;
        w_pass_cnt = r_pass_cnt;
        w_ba_addr  = r_ba_addr;
        w_ba_wr    = r_ba_wr;
        w_ba_rd    = r_ba_rd;
        w_ba_din   = r_ba_din;
        if (w_start_ok) begin
            w_seed     = SEED;
            w_busy     = 1'b1;
            w_done     = 1'b0;
            w_bad      = 1'b0;
            w_err_cnt  = 16'h0000;
            w_pass_cnt = 8'h00;
        end
        case (r_state)
            S_PSTART: begin
                w_lfsr = r_seed;
                w_page = r_seed[PW-1:0];
                w_cnt  = '0;
            end
            S_WR: begin
                if (!r_ba_wr) begin
                    w_ba_wr   = 1'b1;
                    w_ba_addr = {r_page, r_cnt};
                    w_ba_din  = r_lfsr;
                end else if (w_wr_ack) begin
                    w_ba_wr = 1'b0;
                    w_lfsr  = w_lfsr_adv;
                    w_cnt   = r_cnt + LW'(1);
                end
            end
            S_RSTART: begin
                w_lfsr = r_seed;
                w_cnt  = '0;
            end
            S_RD: begin
                if (!r_ba_rd) begin
                    w_ba_rd   = 1'b1;
                    w_ba_addr = {r_page, r_cnt};
                end else if (w_rd_ack) begin
                    w_ba_rd = 1'b0;
                end
            end
            S_PEND: begin
                w_pass_cnt = r_pass_cnt + 8'd1;
                w_seed     = r_lfsr;
                if (!loop) begin
                    w_done = 1'b1;
                    w_busy = 1'b0;
                end
            end
            default: ;
        endcase
        // compare against the replayed LFSR in the cycle read data arrives
        if (w_cmp) begin
            if (ba_dout != r_lfsr) begin
                w_bad = 1'b1;
                if (r_err_cnt != 16'hffff) w_err_cnt = r_err_cnt + 16'd1;
            end
            w_lfsr = w_lfsr_adv;
            w_cnt  = r_cnt + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed     <= SEED;
            r_lfsr     <= SEED;
            r_page     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bad      <= 1'b0;
            r_err_cnt  <= 16'h0000;
            r_pass_cnt <= 8'h00;
            r_ba_addr  <= '0;
            r_ba_wr    <= 1'b0;
            r_ba_rd    <= 1'b0;
            r_ba_din   <= 16'h0000;
        end else begin
            r_seed     <= w_seed;
            r_lfsr     <= w_lfsr;
            r_page     <= w_page;
            r_cnt      <= w_cnt;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_bad      <= w_bad;
            r_err_cnt  <= w_err_cnt;
            r_pass_cnt <= w_pass_cnt;
            r_ba_addr  <= w_ba_addr;
            r_ba_wr    <= w_ba_wr;
            r_ba_rd    <= w_ba_rd;
            r_ba_din   <= w_ba_din;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bad      = r_bad;
    assign err_cnt  = r_err_cnt;
    assign pass_cnt = r_pass_cnt;
    assign ba_addr  = r_ba_addr;
    assign ba_wr    = r_ba_wr;
    assign ba_rd    = r_ba_rd;
    assign ba_din   = r_ba_din;

endmodule

// File: tb/tb_jtsdram_rnd_seq.sv
// Directed bench for jtsdram_rnd_seq with a behavioural SDRAM bank model (variable ack/rdy latency, data corruption).
module tb_jtsdram_rnd_seq;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst_n, start, loop;
    logic          busy, done, bad;
    logic [15:0]   err_cnt;
    logic [7:0]    pass_cnt;
    logic [AW-1:0] ba_addr;
    logic          ba_wr, ba_rd;
    logic [15:0]   ba_din;
    logic          ba_ack, ba_rdy;
    logic [15:0]   ba_dout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtsdram_rnd_seq #(.AW(22), .LW(8), .SEED(16'hcafe)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .loop(loop),
        .busy(busy), .done(done), .bad(bad), .err_cnt(err_cnt), .pass_cnt(pass_cnt),
        .ba_addr(ba_addr), .ba_wr(ba_wr), .ba_rd(ba_rd), .ba_din(ba_din),
        .ba_ack(ba_ack), .ba_rdy(ba_rdy), .ba_dout(ba_dout)
    );

    // bank model controls (written only by the stimulus process)
    int            max_lat = 0;
    bit            hold_rdy = 0;
    bit            corrupt_all = 0;
    bit            corrupt_en = 0;
    logic [AW-1:0] corrupt_addr = '0;

    // bank model state (written only by the model process)
    logic [15:0]   mem [int];
    logic [AW-1:0] wr_addr_log [$];
    logic [15:0]   wr_dat_log [$];
    int            rd_n = 0;
    int            viol = 0;
    int            ack_cnt, rdy_cnt, r;
    bit            rdy_pend, req, req_prev, acked;
    logic [15:0]   rdy_dat, d, din_prev;
    logic [AW-1:0] addr_prev;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ba_ack = 1'b0; ba_rdy = 1'b0; ba_dout = 16'h0000;
            rdy_pend = 0; req_prev = 0; acked = 0; ack_cnt = 0; rdy_cnt = 0;
        end else begin
            ba_ack = 1'b0;
            ba_rdy = 1'b0;
            req = ba_wr || ba_rd;
            if (ba_wr && ba_rd)                 viol++;
            if (req_prev && acked && req)       viol++;
            if (req_prev && !acked && !req)     viol++;
            if (req_prev && req && !acked && (ba_addr !== addr_prev || ba_din !== din_prev)) viol++;
            if (req && rdy_pend)                viol++;
            if (rdy_pend && !hold_rdy) begin
                if (rdy_cnt == 0) begin
                    ba_rdy = 1'b1; ba_dout = rdy_dat; rdy_pend = 0;
                end else rdy_cnt--;
            end
            acked = 0;
            if (req && !rdy_pend) begin
                if (ack_cnt == 0) begin
                    ba_ack = 1'b1;
                    acked = 1;
                    ack_cnt = $urandom_range(max_lat, 0);
                    if (ba_wr) begin
                        mem[int'(ba_addr)] = ba_din;
                        wr_addr_log.push_back(ba_addr);
                        wr_dat_log.push_back(ba_din);
                    end else begin
                        d = mem.exists(int'(ba_addr)) ? mem[int'(ba_addr)] : 16'h0000;
                        if (corrupt_all || (corrupt_en && ba_addr == corrupt_addr)) d = d ^ 16'h0100;
                        r = $urandom_range(max_lat, 0);
                        rd_n++;
                        if (r == 0 && !hold_rdy) begin
                            ba_rdy = 1'b1; ba_dout = d;
                        end else begin
                            rdy_pend = 1; rdy_cnt = (r == 0) ? 0 : r - 1; rdy_dat = d;
                        end
                    end
                end else ack_cnt--;
            end
            req_prev  = req;
            addr_prev = ba_addr;
            din_prev  = ba_din;
        end
    end

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[14] ^ s[12] ^ s[9] ^ s[7] ^ s[4] ^ s[2] ^ s[0];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [15:0] lfsr_n(input logic [15:0] s, input int n);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = lfsr_adv(v);
        return v;
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
        if (done !== 1'b1) begin
            tests++; fails++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", nm, done, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; loop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, bad, err_cnt, pass_cnt, ba_wr, ba_rd} !== 29'h0) begin
            fails++;
            $display("FAIL reset_status: busy=%b done=%b bad=%b err=%h pass=%h wr=%b rd=%b, required all 0",
                     busy, done, bad, err_cnt, pass_cnt, ba_wr, ba_rd);
        end
        tests++;
        if (ba_addr !== 22'h0 || ba_din !== 16'h0) begin
            fails++;
            $display("FAIL reset_bus: addr=%h din=%h, required 0/0", ba_addr, ba_din);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_first_pass();
        int wb, rb, vb, bad_words;
        wb = wr_addr_log.size(); rb = rd_n; vb = viol;
        max_lat = 0; loop = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b1 || ba_wr !== 1'b0) begin
            fails++; $display("FAIL start_edge: busy=%b wr=%b, required 1/0", busy, ba_wr);
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (ba_wr !== 1'b0) begin fails++; $display("FAIL pstart_gap: wr=%b, required 0", ba_wr); end
        @(posedge clk); #1;
        tests++;
        if (ba_wr !== 1'b1 || ba_addr !== 22'h0afe00 || ba_din !== 16'hcafe) begin
            fails++;
            $display("FAIL first_write: wr=%b addr=%h din=%h, required 1/0afe00/cafe", ba_wr, ba_addr, ba_din);
        end
        wait_done(5000, "first_pass");
        tests++;
        if (wr_addr_log.size() - wb != 256 || rd_n - rb != 256) begin
            fails++; $display("FAIL first_counts: writes=%0d reads=%0d, required 256/256", wr_addr_log.size() - wb, rd_n - rb);
        end
        tests++;
        if (wr_addr_log[wb+1] !== 22'h0afe01 || wr_dat_log[wb+1] !== 16'h657f) begin
            fails++;
            $display("FAIL second_write: addr=%h din=%h, required 0afe01/657f", wr_addr_log[wb+1], wr_dat_log[wb+1]);
        end
        bad_words = 0;
        for (int i = 0; i < 256; i++)
            if (wr_dat_log[wb+i] !== lfsr_n(16'hcafe, i) || wr_addr_log[wb+i] !== (22'h0afe00 | 22'(i))) bad_words++;
        tests++;
        if (bad_words != 0) begin fails++; $display("FAIL write_pattern: %0d wrong words, required 0", bad_words); end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 8'd1 || bad !== 1'b0 || err_cnt !== 16'h0) begin
            fails++;
            $display("FAIL first_result: done=%b busy=%b pass=%0d bad=%b err=%0d, required 1/0/1/0/0",
                     done, busy, pass_cnt, bad, err_cnt);
        end
        tests++;
        if (viol != vb) begin fails++; $display("FAIL first_protocol: %0d violations, required 0", viol - vb); end
    endtask

    task automatic test_corrupt();
        corrupt_addr = 22'h0afe05; corrupt_en = 1'b1; max_lat = 0; loop = 1'b0;
        pulse_start();
        wait_done(5000, "corrupt");
        tests++;
        if (bad !== 1'b1 || err_cnt !== 16'd1 || done !== 1'b1 || pass_cnt !== 8'd1) begin
            fails++;
            $display("FAIL corrupt_one: bad=%b err=%0d done=%b pass=%0d, required 1/1/1/1", bad, err_cnt, done, pass_cnt);
        end
        corrupt_en = 1'b0;
    endtask

    task automatic test_loop();
        int wb, vb, n;
        logic [15:0] s2, s3;
        s2 = lfsr_n(16'hcafe, 256);
        s3 = lfsr_n(s2, 256);
        wb = wr_addr_log.size(); vb = viol;
        max_lat = 0; loop = 1'b1;
        pulse_start();
        n = 0;
        while (pass_cnt === 8'd0 && n < 5000) begin @(posedge clk); #1; n++; end
        tests++;
        if (pass_cnt !== 8'd1) begin fails++; $display("FAIL loop_pass1: pass=%0d, required 1", pass_cnt); end
        n = 0;
        while (pass_cnt === 8'd1 && n < 5000) begin @(posedge clk); #1; n++; end
        tests++;
        if (pass_cnt !== 8'd2 || done !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL loop_pass2: pass=%0d done=%b busy=%b, required 2/0/1", pass_cnt, done, busy);
        end
        loop = 1'b0;
        wait_done(5000, "loop");
        tests++;
        if (pass_cnt !== 8'd3 || wr_addr_log.size() - wb != 768) begin
            fails++; $display("FAIL loop_pass3: pass=%0d writes=%0d, required 3/768", pass_cnt, wr_addr_log.size() - wb);
        end
        tests++;
        if (wr_addr_log[wb+256] !== {s2[13:0], 8'h00} || wr_dat_log[wb+256] !== s2) begin
            fails++;
            $display("FAIL loop_page2: addr=%h din=%h, required %h/%h", wr_addr_log[wb+256], wr_dat_log[wb+256], {s2[13:0], 8'h00}, s2);
        end
        tests++;
        if (wr_addr_log[wb+512] !== {s3[13:0], 8'h00} || wr_dat_log[wb+512] !== s3) begin
            fails++;
            $display("FAIL loop_page3: addr=%h din=%h, required %h/%h", wr_addr_log[wb+512], wr_dat_log[wb+512], {s3[13:0], 8'h00}, s3);
        end
        tests++;
        if (viol != vb || err_cnt !== 16'h0 || bad !== 1'b0) begin
            fails++; $display("FAIL loop_clean: viol=%0d err=%0d bad=%b, required 0/0/0", viol - vb, err_cnt, bad);
        end
    endtask

    task automatic test_random_latency();
        int rb, vb;
        rb = rd_n; vb = viol;
        max_lat = 10; loop = 1'b0;
        pulse_start();
        wait_done(30000, "random_lat");
        tests++;
        if (err_cnt !== 16'h0 || bad !== 1'b0 || pass_cnt !== 8'd1 || rd_n - rb != 256) begin
            fails++;
            $display("FAIL random_lat_result: err=%0d bad=%b pass=%0d reads=%0d, required 0/0/1/256", err_cnt, bad, pass_cnt, rd_n - rb);
        end
        tests++;
        if (viol != vb) begin fails++; $display("FAIL random_lat_protocol: %0d violations, required 0", viol - vb); end
    endtask

    task automatic test_start_while_busy();
        int wb, rb, n;
        wb = wr_addr_log.size(); rb = rd_n;
        max_lat = 3; corrupt_all = 1'b1; loop = 1'b0;
        pulse_start();
        n = 0;
        while (rd_n - rb < 20 && n < 10000) begin @(posedge clk); #1; n++; end
        pulse_start();
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b1 || pass_cnt !== 8'd0 || bad !== 1'b1) begin
            fails++; $display("FAIL busy_start_mid: busy=%b pass=%0d bad=%b, required 1/0/1", busy, pass_cnt, bad);
        end
        wait_done(15000, "busy_start");
        tests++;
        if (wr_addr_log.size() - wb != 256 || rd_n - rb != 256 || err_cnt !== 16'h0100 || pass_cnt !== 8'd1) begin
            fails++;
            $display("FAIL busy_start_end: writes=%0d reads=%0d err=%h pass=%0d, required 256/256/0100/1",
                     wr_addr_log.size() - wb, rd_n - rb, err_cnt, pass_cnt);
        end
    endtask

    task automatic test_saturate();
        max_lat = 0; corrupt_all = 1'b1; loop = 1'b0;
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        force dut.r_err_cnt = 16'hff80;
        @(posedge clk); #1;
        release dut.r_err_cnt;
        wait_done(5000, "saturate");
        tests++;
        if (err_cnt !== 16'hffff || bad !== 1'b1) begin
            fails++; $display("FAIL err_saturate: err=%h bad=%b, required ffff/1", err_cnt, bad);
        end
        corrupt_all = 1'b0;
    endtask

    task automatic test_reset_rwait();
        int rb, wb, n;
        rb = rd_n;
        max_lat = 0; hold_rdy = 1'b1; loop = 1'b0;
        pulse_start();
        n = 0;
        while (rd_n == rb && n < 5000) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (busy !== 1'b1 || ba_rd !== 1'b0) begin
            fails++; $display("FAIL rwait_reached: busy=%b rd=%b, required 1/0", busy, ba_rd);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, bad, err_cnt, pass_cnt, ba_wr, ba_rd} !== 29'h0 || ba_addr !== 22'h0 || ba_din !== 16'h0) begin
            fails++;
            $display("FAIL reset_rwait: busy=%b done=%b bad=%b err=%h pass=%h wr=%b rd=%b addr=%h din=%h, required all 0",
                     busy, done, bad, err_cnt, pass_cnt, ba_wr, ba_rd, ba_addr, ba_din);
        end
        hold_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wb = wr_addr_log.size();
        pulse_start();
        wait_done(5000, "after_reset");
        tests++;
        if (wr_dat_log[wb] !== 16'hcafe || wr_addr_log[wb] !== 22'h0afe00 || err_cnt !== 16'h0 || pass_cnt !== 8'd1) begin
            fails++;
            $display("FAIL restart_after_reset: din=%h addr=%h err=%0d pass=%0d, required cafe/0afe00/0/1",
                     wr_dat_log[wb], wr_addr_log[wb], err_cnt, pass_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_pass();
        test_corrupt();
        test_loop();
        test_random_latency();
        test_start_while_busy();
        test_saturate();
        test_reset_rwait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
